// File: rtl/stream_light_ctrl.sv
// Run/stop/reverse controller for an LED chaser: debounces three raw buttons,
// runs an IDLE/RUN/PAUSE state machine and paces Step pulses by a selectable rate.
module stream_light_ctrl #(
   parameter int DB_CYCLES   = 1000000,
   parameter int STEP_CYCLES = 50000000
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Stop,
   input  logic       Reverse,
   input  logic [1:0] Speed,
   output logic       Step,
   output logic       Dir,
   output logic [1:0] State,
   output logic       Running
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   logic [2:0]     raw;
   logic [2:0]     sync_a;
   logic [2:0]     sync_b;
   logic [2:0]     deb;
   logic [2:0]     press;
   logic [DBW-1:0] db_cnt [3];

   logic           run_p;
   logic           stop_p;
   logic           rev_p;

   state_t         state;
   state_t         state_nxt;

   logic [SW-1:0]  step_cnt;
   logic [31:0]    span;
   logic [31:0]    term;
   logic           at_term;
   logic           advance;

   assign raw = {Reverse, Stop, Run};

   // Bit 0 = Run, bit 1 = Stop, bit 2 = Reverse throughout the button path.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync_a <= '0;
         sync_b <= '0;
         deb    <= '0;
         for (int i = 0; i < 3; i++)
            db_cnt[i] <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // A press is the cycle in which a debounced level is about to rise.
   always_comb begin
      press = '0;
      for (int i = 0; i < 3; i++)
         press[i] = sync_b[i] & ~deb[i] & (db_cnt[i] == DB_LAST);
   end

   assign run_p  = press[0];
   assign stop_p = press[1];
   assign rev_p  = press[2];

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Stop outranks Run whenever both arrive together.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!stop_p && run_p) state_nxt = RUN;
         RUN:     if (stop_p)           state_nxt = PAUSE;
         PAUSE:   if (stop_p)           state_nxt = IDLE;
                  else if (run_p)       state_nxt = RUN;
         default:                       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      State   = state;
      Running = (state == RUN);
      advance = (state == RUN) && !stop_p;
      Step    = advance && at_term;
   end

   always_comb begin
      span    = 32'(STEP_CYCLES) >> Speed;
      term    = (span == 32'd0) ? 32'd0 : span - 32'd1;
      at_term = (32'(step_cnt) >= term);
   end

   // Holding in the cycle RUN is left keeps the count intact for resume.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         step_cnt <= '0;
      else if (state == IDLE)
         step_cnt <= '0;
      else if (advance)
         step_cnt <= at_term ? '0 : step_cnt + SW'(1);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         Dir <= 1'b0;
      else if (rev_p)
         Dir <= ~Dir;
   end

endmodule

// File: tb/tb_stream_light_ctrl.sv
// Bench for stream_light_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a window-based model.
module tb_stream_light_ctrl;

   localparam int DB   = 4;
   localparam int STEP = 8;

   logic       CLK;
   logic       Reset;
   logic       Run;
   logic       Stop;
   logic       Reverse;
   logic [1:0] Speed;
   logic       Step;
   logic       Dir;
   logic [1:0] State;
   logic       Running;

   stream_light_ctrl #(
      .DB_CYCLES  (DB),
      .STEP_CYCLES(STEP)
   ) dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .Run    (Run),
      .Stop   (Stop),
      .Reverse(Reverse),
      .Speed  (Speed),
      .Step   (Step),
      .Dir    (Dir),
      .State  (State),
      .Running(Running)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit modelOn = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Model: a button's debounced level flips once its last DB delayed samples
   // all disagree with it; the delayed sample lags the pin by two edges.
   logic [DB-1:0] mWin [3];
   bit mDeb [3];
   bit mPrevRaw [3];
   bit mPend [3];
   int mState;
   bit mDir;
   int mCnt;

   function automatic int termCount(input logic [1:0] sp);
      int s;
      s = STEP >> sp;
      return (s < 1) ? 0 : s - 1;
   endfunction

   task automatic modelReset();
      for (int b = 0; b < 3; b++) begin
         mWin[b]     = '0;
         mDeb[b]     = 0;
         mPrevRaw[b] = 0;
         mPend[b]    = 0;
      end
      mState = 0;
      mDir   = 0;
      mCnt   = 0;
   endtask

   task automatic modelTick(input bit r0, input bit r1, input bit r2, input logic [1:0] sp);
      int nxt;
      bit all;
      bit rawNow [3];
      rawNow[0] = r0;
      rawNow[1] = r1;
      rawNow[2] = r2;
      nxt = mState;
      if (mPend[1]) begin
         if (mState == 1) nxt = 2;
         else if (mState == 2) nxt = 0;
      end else if (mPend[0] && mState != 1) begin
         nxt = 1;
      end
      if (mState == 0)
         mCnt = 0;
      else if (mState == 1 && nxt == 1)
         mCnt = (mCnt >= termCount(sp)) ? 0 : mCnt + 1;
      if (mPend[2]) mDir = !mDir;
      mState = nxt;
      for (int b = 0; b < 3; b++) begin
         mWin[b] = {mWin[b][DB-2:0], mPrevRaw[b]};
         all = mDeb[b] ? (mWin[b] == '0) : (mWin[b] == '1);
         mPend[b] = 0;
         if (all) begin
            mDeb[b]  = !mDeb[b];
            mPend[b] = mDeb[b];
         end
         mPrevRaw[b] = rawNow[b];
      end
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge CLK or negedge Reset);
         if (!Reset)
            modelReset();
         else
            modelTick(Run, Stop, Reverse, Speed);
      end
   end

   initial begin
      bit expStep;
      forever begin
         @(negedge CLK);
         if (modelOn) begin
            expStep = (mState == 1) && !mPend[1] && (mCnt >= termCount(Speed));
            checkOutput("State", State, mState);
            checkOutput("Running", Running, (mState == 1) ? 1 : 0);
            checkOutput("Dir", Dir, mDir);
            checkOutput("Step", Step, expStep);
         end
      end
   end

   // Event log used by the directed scenarios.
   int   runStart    = -1;
   int   pauseStart  = -1;
   int   transitions = 0;
   int   pauseSteps  = 0;
   int   stepTimes[$];
   logic [1:0] monPrev = 2'b00;

   initial begin
      forever begin
         @(negedge CLK);
         if (State == 2'b01 && monPrev != 2'b01) runStart = cyc;
         if (State == 2'b10 && monPrev != 2'b10) pauseStart = cyc;
         if (State != monPrev) transitions++;
         if (Step) begin
            stepTimes.push_back(cyc);
            if (State == 2'b10) pauseSteps++;
         end
         monPrev = State;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [1:0] sp);
      @(posedge CLK);
      #1;
      Run     = r;
      Stop    = s;
      Reverse = v;
      Speed   = sp;
   endtask

   task automatic pressButton(input int which, input int len);
      if (which == 0) Run = 1; else if (which == 1) Stop = 1; else Reverse = 1;
      waitCycles(len);
      if (which == 0) Run = 0; else if (which == 1) Stop = 0; else Reverse = 0;
   endtask

   task automatic checkGaps(input string name, input int from);
      int minGap, maxGap;
      minGap = 1000;
      maxGap = 0;
      for (int i = from + 1; i < stepTimes.size(); i++) begin
         if (stepTimes[i] - stepTimes[i-1] < minGap) minGap = stepTimes[i] - stepTimes[i-1];
         if (stepTimes[i] - stepTimes[i-1] > maxGap) maxGap = stepTimes[i] - stepTimes[i-1];
      end
      checkOutput({name, "_min_gap"}, minGap, 8);
      checkOutput({name, "_max_gap"}, maxGap, 8);
   endtask

   initial begin
      int pressCyc, t0, n0, held, lastStep, found, holdR, holdS, holdV;
      logic [4:0] pat;

      Run = 0; Stop = 0; Reverse = 0; Speed = 2'd0; Reset = 0;
      modelOn = 1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("reset_state", State, 0);
      checkOutput("reset_step", Step, 0);
      checkOutput("reset_dir", Dir, 0);
      checkOutput("reset_running", Running, 0);
      @(posedge CLK);
      #1 Reset = 1;
      waitCycles(2);

      // Held Run from IDLE enters RUN once, six edges after the press.
      stepTimes.delete();
      t0 = transitions;
      pressCyc = cyc;
      pressButton(0, 10);
      waitCycles(2);
      checkOutput("run_entry_delay", runStart - pressCyc, 6);
      checkOutput("run_transitions", transitions - t0, 1);
      checkOutput("run_state", State, 1);

      // Speed 0 cadence.
      waitCycles(40);
      checkOutput("speed0_step_count", stepTimes.size(), 5);
      if (stepTimes.size() >= 3) begin
         checkOutput("first_step_delay", stepTimes[0] - runStart, 7);
         checkGaps("speed0", 0);
      end

      // Drop to Speed 2 while the count is 5.
      found = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         #1;
         if (stepTimes.size() > 0 && cyc == stepTimes[$] + 6) begin
            found = 1;
            break;
         end
      end
      checkOutput("reach_count5", found, 1);
      if (found == 1) begin
         Speed = 2'd2;
         pat = '0;
         for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            pat = {pat[3:0], Step};
         end
         checkOutput("speed2_pattern", pat, 5'b10101);
      end
      applyStimulus(0, 0, 0, 2'd0);
      waitCycles(10);

      // Pause holds the count; resume continues from it.
      pauseSteps = 0;
      pressButton(1, 8);
      waitCycles(20);
      checkOutput("pause_state", State, 2);
      checkOutput("pause_steps", pauseSteps, 0);
      lastStep = (stepTimes.size() > 0) ? stepTimes[$] : 0;
      held = pauseStart - lastStep - 2;
      n0 = stepTimes.size();
      pressButton(0, 8);
      waitCycles(12);
      checkOutput("resume_state", State, 1);
      checkOutput("resume_has_step", (stepTimes.size() > n0) ? 1 : 0, 1);
      if (stepTimes.size() > n0)
         checkOutput("resume_first_step", stepTimes[n0] - runStart, 7 - held);

      // Run and Stop together in PAUSE go to IDLE; a short Reverse glitch is ignored.
      pressButton(1, 8);
      waitCycles(4);
      checkOutput("pause_again", State, 2);
      Run = 1; Stop = 1;
      waitCycles(8);
      Run = 0; Stop = 0;
      waitCycles(2);
      checkOutput("both_in_pause", State, 0);
      pressButton(2, 3);
      waitCycles(8);
      checkOutput("rev_glitch_dir", Dir, 0);

      // Reverse during RUN leaves the cadence intact.
      pressButton(0, 8);
      waitCycles(4);
      stepTimes.delete();
      pressButton(2, 8);
      waitCycles(24);
      checkOutput("rev_dir", Dir, 1);
      checkOutput("rev_step_count", (stepTimes.size() >= 3) ? 1 : 0, 1);
      if (stepTimes.size() >= 3) checkGaps("rev", 0);

      // Reset with the count at 6.
      found = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         #1;
         if (stepTimes.size() > 0 && cyc == stepTimes[$] + 7) begin
            found = 1;
            break;
         end
      end
      checkOutput("reach_count6", found, 1);
      #2 Reset = 0;
      #1;
      checkOutput("midrun_reset_state", State, 0);
      checkOutput("midrun_reset_step", Step, 0);
      checkOutput("midrun_reset_dir", Dir, 0);
      checkOutput("midrun_reset_running", Running, 0);
      waitCycles(2);
      Reset = 1;
      n0 = stepTimes.size();
      waitCycles(30);
      checkOutput("no_step_after_reset", stepTimes.size() - n0, 0);
      checkOutput("idle_after_reset", State, 0);

      // Randomized buttons, speeds and occasional resets.
      holdR = 0; holdS = 0; holdV = 0;
      for (int n = 0; n < 2500; n++) begin
         @(posedge CLK);
         #1;
         Reset = 1;
         if (holdR == 0) begin Run = ~Run; holdR = $urandom_range(1, 10); end
         else holdR--;
         if (holdS == 0) begin Stop = ~Stop; holdS = $urandom_range(1, 16); end
         else holdS--;
         if (holdV == 0) begin Reverse = ~Reverse; holdV = $urandom_range(1, 12); end
         else holdV--;
         if ($urandom_range(0, 15) == 0) Speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) Reset = 0;
      end
      applyStimulus(0, 0, 0, 2'd0);
      Reset = 1;
      waitCycles(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
